// File: rtl/multi_chan_level_fsm.sv
// N-channel glitch-filtered level tracker with complementary one-hot outputs.
// Optional registered rise/fall pulses are built when LEVEL_FSM_EDGE_EN is defined.

module multi_chan_level_fsm_ch #(
    parameter int FILT    = 3,
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic a_i,
    output logic lvl_o
`ifdef LEVEL_FSM_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);
    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    typedef enum logic {LVL_LO = 1'b0, LVL_HI = 1'b1} lvl_e;

    lvl_e          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= lvl_e'(RST_VAL);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter survives disabled cycles; only a matching sample clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            if (a_i == logic'(state_q)) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                state_d = lvl_e'(a_i);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign lvl_o = (state_q == LVL_HI);

`ifdef LEVEL_FSM_EDGE_EN
    logic rise_q, fall_q;

    // state_d equals state_q on disabled cycles, so pulses self-clear regardless of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == LVL_LO) && (state_d == LVL_HI);
            fall_q <= (state_q == LVL_HI) && (state_d == LVL_LO);
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif
endmodule

module multi_chan_level_fsm #(
    parameter int CH      = 4,
    parameter int FILT    = 3,
    parameter bit RST_VAL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [CH-1:0] a_i,
    output logic [CH-1:0] out1_o,
    output logic [CH-1:0] out2_o
`ifdef LEVEL_FSM_EDGE_EN
    ,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o
`endif
);
    logic [CH-1:0] lvl;

    multi_chan_level_fsm_ch #(
        .FILT   (FILT),
        .RST_VAL(RST_VAL)
    ) u_ch [CH-1:0] (
        .clk   (clk),
        .reset (reset),
        .en_i  (en_i),
        .a_i   (a_i),
        .lvl_o (lvl)
`ifdef LEVEL_FSM_EDGE_EN
        ,
        .rise_o(rise_o),
        .fall_o(fall_o)
`endif
    );

    assign out2_o = lvl;
    assign out1_o = ~lvl;
endmodule

// File: tb/tb_multi_chan_level_fsm.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares one entry after every rising edge.

module tb_multi_chan_level_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en, en1;
    logic [3:0] a;
    logic [0:0] a1;
    logic [3:0] out1, out2, rise, fall;
    logic [0:0] out1_s, out2_s, rise_s, fall_s;

    multi_chan_level_fsm #(.CH(4), .FILT(3), .RST_VAL(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .en_i  (en),
        .a_i   (a),
        .out1_o(out1),
        .out2_o(out2)
`ifdef LEVEL_FSM_EDGE_EN
        ,
        .rise_o(rise),
        .fall_o(fall)
`endif
    );

    multi_chan_level_fsm #(.CH(1), .FILT(1), .RST_VAL(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .en_i  (en1),
        .a_i   (a1),
        .out1_o(out1_s),
        .out2_o(out2_s)
`ifdef LEVEL_FSM_EDGE_EN
        ,
        .rise_o(rise_s),
        .fall_o(fall_s)
`endif
    );

`ifndef LEVEL_FSM_EDGE_EN
    assign rise   = '0;
    assign fall   = '0;
    assign rise_s = '0;
    assign fall_s = '0;
`endif

    typedef struct packed {
        logic [3:0] o2;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [3:0] o1, input logic [3:0] o2,
                       input logic [3:0] r, input logic [3:0] f, input exp_t x,
                       input logic [3:0] m);
        bit bad;
        bad = 1'b0;
        vectors++;
        if ((o2 & m) !== (x.o2 & m)) begin
            $display("FAIL %s out2 #%0d: got %h expected %h", nm, vectors, o2 & m, x.o2 & m);
            bad = 1'b1;
        end
        if ((o1 & m) !== (~x.o2 & m)) begin
            $display("FAIL %s out1 #%0d: got %h expected %h", nm, vectors, o1 & m, ~x.o2 & m);
            bad = 1'b1;
        end
`ifdef LEVEL_FSM_EDGE_EN
        if ((r & m) !== (x.r & m)) begin
            $display("FAIL %s rise #%0d: got %h expected %h", nm, vectors, r & m, x.r & m);
            bad = 1'b1;
        end
        if ((f & m) !== (x.f & m)) begin
            $display("FAIL %s fall #%0d: got %h expected %h", nm, vectors, f & m, x.f & m);
            bad = 1'b1;
        end
`endif
        if (bad) miscompares++;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                chk("ch4", out1, out2, rise, fall, x, 4'hF);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                chk("filt1", {3'b0, out1_s}, {3'b0, out2_s}, {3'b0, rise_s}, {3'b0, fall_s}, x, 4'h1);
            end
        end
    end

    task automatic step0(input logic r, input logic e, input logic [3:0] av,
                         input logic [3:0] o2, input logic [3:0] rs, input logic [3:0] fl);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; a = av;
        x.o2 = o2; x.r = rs; x.f = fl;
        q0.push_back(x);
    endtask

    task automatic step1(input logic r, input logic e, input logic av,
                         input logic o2, input logic rs, input logic fl);
        exp_t x;
        @(negedge clk);
        reset = r; en1 = e; a1[0] = av;
        x.o2 = {3'b0, o2}; x.r = {3'b0, rs}; x.f = {3'b0, fl};
        q1.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; a = 4'hF; en1 = 1'b0; a1 = 1'b1;
        // reset state
        step0(1, 0, 4'hF, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hF, 4'hF, 4'h0, 4'h0);
        // ch0 low for 3 edges
        step0(0, 1, 4'hE, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hE, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hE, 4'hE, 4'h0, 4'h1);
        step0(0, 1, 4'hE, 4'hE, 4'h0, 4'h0);
        // ch1 glitch clears count
        step0(0, 1, 4'hC, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hC, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hE, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hC, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hC, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hE, 4'hE, 4'h0, 4'h0);
        // ch2 count held across disabled cycles
        step0(0, 1, 4'hA, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hA, 4'hE, 4'h0, 4'h0);
        repeat (5) step0(0, 0, 4'hA, 4'hE, 4'h0, 4'h0);
        step0(0, 1, 4'hA, 4'hA, 4'h0, 4'h4);
        step0(0, 0, 4'hA, 4'hA, 4'h0, 4'h0);
        // reset mid-count on ch1
        step0(0, 1, 4'h8, 4'hA, 4'h0, 4'h0);
        step0(0, 1, 4'h8, 4'hA, 4'h0, 4'h0);
        step0(1, 1, 4'h8, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hD, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hD, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'hD, 4'hD, 4'h0, 4'h2);
        step0(0, 1, 4'hD, 4'hD, 4'h0, 4'h0);
        // ch1 rising edge
        step0(0, 1, 4'hF, 4'hD, 4'h0, 4'h0);
        step0(0, 1, 4'hF, 4'hD, 4'h0, 4'h0);
        step0(0, 1, 4'hF, 4'hF, 4'h2, 4'h0);
        step0(0, 1, 4'hF, 4'hF, 4'h0, 4'h0);
        // all channels switch together
        step0(0, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'h0, 4'h0, 4'h0, 4'hF);
        step0(0, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        step0(0, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        step0(0, 1, 4'hF, 4'hF, 4'hF, 4'h0);
        step0(0, 1, 4'hF, 4'hF, 4'h0, 4'h0);
        // reset kills a pending pulse
        step0(0, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        step0(0, 1, 4'h0, 4'h0, 4'h0, 4'hF);
        step0(1, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        step0(0, 0, 4'h0, 4'hF, 4'h0, 4'h0);
        // FILT=1 single channel follower
        en = 1'b0;
        step1(1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step1(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        step1(0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        step1(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        step1(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step1(0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        step1(0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            $display("FAIL drain: %0d/%0d expectations left unchecked, expected 0", q0.size(), q1.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
